// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - single-clock FIFO with registered read, occupancy flags and sticky errors
module sync_fifo_mem #(
    parameter int DATASIZE   = 8,
    parameter int ADDRSIZE   = 6,
    parameter int AFULL_LVL  = (1 << ADDRSIZE) - 4,
    parameter int AEMPTY_LVL = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                winc,
    input  logic                rinc,
    input  logic                clr_err,
    output logic [DATASIZE-1:0] rdata,
    output logic                rd_valid,
    output logic                wr_ack,
    output logic                wfull,
    output logic                rempty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [ADDRSIZE:0]   count,
    output logic                overflow,
    output logic                underflow
);

    localparam int DEPTH = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] AFULL_CMP  = (ADDRSIZE+1)'(AFULL_LVL);
    localparam logic [ADDRSIZE:0] AEMPTY_CMP = (ADDRSIZE+1)'(AEMPTY_LVL);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // and plain binary increment wraps modulo 2*DEPTH without extra logic.
    logic [ADDRSIZE:0]   r_wptr;
    logic [ADDRSIZE:0]   r_rptr;
    logic [DATASIZE-1:0] r_mem [0:DEPTH-1];
    logic [DATASIZE-1:0] r_rdata;
    logic                r_rd_valid;
    logic                r_wr_ack;
    logic                r_overflow;
    logic                r_underflow;

    logic                w_full;
    logic                w_empty;
    logic                w_wr_en;
    logic                w_rd_en;
    logic [ADDRSIZE:0]   w_count;

    // Status is decoded purely from the registered pointers, so it moves in
    // the same cycle the pointers do.
    assign w_full  = (r_wptr[ADDRSIZE-1:0] == r_rptr[ADDRSIZE-1:0]) &&
                     (r_wptr[ADDRSIZE] != r_rptr[ADDRSIZE]);
    assign w_empty = (r_wptr == r_rptr);
    assign w_count = r_wptr - r_rptr;

    // A full FIFO still drains and an empty FIFO still fills; the blocked
    // side of a simultaneous request is simply dropped (no fall-through).
    assign w_wr_en = winc && !w_full;
    assign w_rd_en = rinc && !w_empty;

    // Storage array is not reset; stale entries are unreachable once the
    // pointers are cleared.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_en) begin
            r_mem[r_wptr[ADDRSIZE-1:0]] <= wdata;
        end
    end

    // Pointer advance on accepted requests
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Registered read port and one-cycle handshake pulses; rdata holds when idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata    <= '0;
            r_rd_valid <= 1'b0;
            r_wr_ack   <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_en;
            r_wr_ack   <= w_wr_en;
            if (w_rd_en) begin
                r_rdata <= r_mem[r_rptr[ADDRSIZE-1:0]];
            end
        end
    end

    // Sticky error flags; a new error wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (winc && w_full) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rinc && w_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign rdata        = r_rdata;
    assign rd_valid     = r_rd_valid;
    assign wr_ack       = r_wr_ack;
    assign wfull        = w_full;
    assign rempty       = w_empty;
    assign count        = w_count;
    assign almost_full  = (w_count >= AFULL_CMP);
    assign almost_empty = (w_count <= AEMPTY_CMP);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: doc/sync_fifo_mem.md
SYNC_FIFO_MEM -- requirements
Module: sync_fifo_mem

Interface
REQ-001 SHALL have parameter DATASIZE, default 8, data word width in bits.
REQ-002 SHALL have parameter ADDRSIZE, default 6, address bits; DEPTH = 2^ADDRSIZE.
REQ-003 SHALL have parameter AFULL_LVL, default DEPTH-4, almost_full threshold.
REQ-004 SHALL have parameter AEMPTY_LVL, default 4, almost_empty threshold.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-007 SHALL have port wdata, input, DATASIZE, write data.
REQ-008 SHALL have port winc, input, 1, write request.
REQ-009 SHALL have port rinc, input, 1, read request.
REQ-010 SHALL have port clr_err, input, 1, clears sticky error flags.
REQ-011 SHALL have port rdata, output, DATASIZE, registered read data.
REQ-012 SHALL have port rd_valid, output, 1, rdata valid this cycle.
REQ-013 SHALL have port wr_ack, output, 1, previous-cycle write accepted.
REQ-014 SHALL have port wfull, output, 1, FIFO full.
REQ-015 SHALL have port rempty, output, 1, FIFO empty.
REQ-016 SHALL have port almost_full, output, 1, count >= AFULL_LVL.
REQ-017 SHALL have port almost_empty, output, 1, count <= AEMPTY_LVL.
REQ-018 SHALL have port count, output, ADDRSIZE+1, current occupancy, 0..DEPTH.
REQ-019 SHALL have port overflow, output, 1, sticky: write attempted while full.
REQ-020 SHALL have port underflow, output, 1, sticky: read attempted while empty.

Function
REQ-021 SHALL keep write and read pointers ADDRSIZE+1 bits wide, binary; the low ADDRSIZE bits address memory and the MSB is the wrap bit.
REQ-022 SHALL assert wfull when pointer low bits are equal and MSBs differ, and rempty when all bits are equal; both are decoded from registered pointers.
REQ-023 SHALL accept a write (mem[wptr] <= wdata, wptr+1) only when winc=1 and wfull=0; wr_ack SHALL be 1 in the following cycle only, otherwise 0.
REQ-024 SHALL accept a read only when rinc=1 and rempty=0: rdata <= mem[rptr], rptr+1, rd_valid=1 in the following cycle only.
REQ-025 SHALL hold rdata at its last value when no read is accepted; rdata SHALL never be driven to Z or X after reset.
REQ-026 SHALL give read latency exactly 1 clock, from the accepted rinc edge to rd_valid/rdata.
REQ-027 SHALL on simultaneous accepted write and read keep count unchanged and advance both pointers.
REQ-028 SHALL when full with winc=1 and rinc=1 perform the read only, reject the write, and set overflow.
REQ-029 SHALL when empty with winc=1 and rinc=1 perform the write only, reject the read (no fall-through), and set underflow.
REQ-030 SHALL wrap pointers modulo 2*DEPTH with no special-case logic.
REQ-031 SHALL update count, wfull, rempty, almost_full and almost_empty in the same cycle as the pointer changes.
REQ-032 SHALL set overflow on winc=1 with wfull=1, and underflow on rinc=1 with rempty=1; both SHALL stay set until clr_err=1 or reset, and set takes priority over a same-cycle clr_err.

Reset
REQ-033 SHALL, with rst_n=0 at a clk edge, clear both pointers and count to 0 and set rempty=1, almost_empty=1, wfull=0, almost_full=0 (when AFULL_LVL>0), wr_ack=0, rd_valid=0, overflow=0, underflow=0 and rdata=0.
REQ-034 SHALL let reset override any same-cycle winc/rinc; memory contents need not be cleared.
REQ-035 SHALL, on reset mid-operation, discard all stored data; the first read after reset returns only data written after reset.

Verification (DATASIZE=8, ADDRSIZE=2, AFULL_LVL=3, AEMPTY_LVL=1)
REQ-036 SHALL test: write 0xA1,0xA2,0xA3,0xA4 on consecutive cycles -> wr_ack 1 each following cycle; count 1,2,3,4; almost_full at count 3; wfull at 4.
REQ-037 SHALL test: from full, winc with 0x55 -> wr_ack=0, overflow=1, count stays 4; then clr_err -> overflow=0.
REQ-038 SHALL test: read 4 times from full -> rdata 0xA1..0xA4 with rd_valid=1, each 1 cycle after rinc; rempty=1 after 4th; 5th rinc -> rd_valid=0, underflow=1, rdata stays 0xA4.
REQ-039 SHALL test: count=2, winc+rinc together for 10 cycles across pointer wrap -> count stays 2, data order preserved.
REQ-040 SHALL test: empty, winc(0x77)+rinc same cycle -> count=1, rd_valid=0, underflow=1; next read returns 0x77.
REQ-041 SHALL test: rst_n=0 with count=3 -> next cycle count=0, rempty=1, all flags 0, rdata=0x00.
